// File: rtl/mem_responder.sv
// mem_responder: word-organised memory behind a valid/ready request/response
// handshake. Each access waits a fixed WAIT_CYCLES after acceptance, then
// performs an RV32I-style byte/half/word load or store with little-endian
// lanes, and holds the result until the CPU takes it.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mode,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // Wait counter must hold WAIT_CYCLES and never be zero bits wide.
  localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;   // byte-address bits actually used

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // RV32I funct3 encodings
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             write_q,      write_d;
  logic [AW-1:0]    addr_q,       addr_d;
  logic [31:0]      wdata_q,      wdata_d;
  logic [2:0]       mode_q,       mode_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q,   resp_err_d;

  logic [31:0] mem_q [DEPTH];

  // Upper byte-address bits wrap away; they are deliberately left unconnected.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  // Access decode, driven only from the latched request.
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic                  acc_err;
  logic [3:0]            acc_be;
  logic [31:0]           acc_wword;
  logic [31:0]           acc_load;
  logic                  access_now;
  logic                  mem_we;

  assign idx        = addr_q[AW-1:2];
  assign lane       = addr_q[1:0];
  assign rd_word    = mem_q[idx];
  assign rd_shift   = rd_word >> {lane, 3'b000};
  assign rd_byte    = rd_shift[7:0];
  assign rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign access_now = (state_q == ST_WAIT) && (cnt_q == '0);
  // Reset wins over a store that reaches its access cycle on the same edge.
  assign mem_we     = access_now && write_q && !acc_err && !rst;

  // Legality check, byte enables and load extension for the pending access.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned (latch).
    acc_err   = 1'b0;
    acc_be    = 4'b0000;
    acc_wword = wdata_q;
    acc_load  = 32'h0;
    unique case (mode_q)
      MODE_B: begin
        // Replicating the byte across all lanes lets the enable pick the lane.
        acc_be    = 4'b0001 << lane;
        acc_wword = {4{wdata_q[7:0]}};
        acc_load  = {{24{rd_byte[7]}}, rd_byte};
      end
      MODE_H: begin
        if (lane[0]) begin
          acc_err = 1'b1;
        end else begin
          acc_be    = lane[1] ? 4'b1100 : 4'b0011;
          acc_wword = {2{wdata_q[15:0]}};
          acc_load  = {{16{rd_half[15]}}, rd_half};
        end
      end
      MODE_W: begin
        if (lane != 2'b00) begin
          acc_err = 1'b1;
        end else begin
          acc_be    = 4'b1111;
          acc_wword = wdata_q;
          acc_load  = rd_word;
        end
      end
      MODE_BU: begin
        if (write_q) acc_err = 1'b1;
        else         acc_load = {24'h0, rd_byte};
      end
      MODE_HU: begin
        if (write_q || lane[0]) acc_err = 1'b1;
        else                    acc_load = {16'h0, rd_half};
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mode_d       = mode_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          mode_d  = req_mode;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Stores and rejected requests both return zero data.
          resp_rdata_d = (acc_err || write_q) ? 32'h0 : acc_load;
          resp_err_d   = acc_err;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      mode_q       <= 3'b000;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mode_q       <= mode_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Byte-enabled array write, only in the access cycle of a legal store.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive rst and map onto
    // plain RAM rather than a bank of resettable flops.
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem_q[idx][8*b +: 8] <= acc_wword[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: DUT 0 uses the default parameters, DUT 1 runs
// with zero wait states and a small array to exercise wrap and 1-edge latency.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]       req_valid, req_write, resp_ready;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][2:0]  req_mode;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  logic [1:0]       req_ready_v, resp_valid_v, resp_err_v;
  logic [1:0][31:0] resp_rdata_v;
  assign req_ready_v  = {b_req_ready,  a_req_ready};
  assign resp_valid_v = {b_resp_valid, a_resp_valid};
  assign resp_err_v   = {b_resp_err,   a_resp_err};
  assign resp_rdata_v = {b_resp_rdata, a_resp_rdata};

  mem_responder u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[0]),
    .req_ready  (a_req_ready),
    .req_write  (req_write[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .req_mode   (req_mode[0]),
    .resp_valid (a_resp_valid),
    .resp_ready (resp_ready[0]),
    .resp_rdata (a_resp_rdata),
    .resp_err   (a_resp_err)
  );

  mem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(0)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[1]),
    .req_ready  (b_req_ready),
    .req_write  (req_write[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .req_mode   (req_mode[1]),
    .resp_valid (b_resp_valid),
    .resp_ready (resp_ready[1]),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request/response. Expected result goes on the scoreboard
  // when the request is driven and is popped when the response appears.
  task automatic transact(input string name, input int d, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] mode, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
    int   wc;
    int   waitc;
    int   lat;
    exp_t e;
    exp_t pushed;
    wc = (d == 0) ? 2 : 0;
    pushed.rdata = exp_rdata;
    pushed.err   = exp_err;
    sb_q.push_back(pushed);

    waitc = 0;
    while (!req_ready_v[d] && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    check({name, ":ready_idle"}, {31'b0, req_ready_v[d]}, 32'd1);

    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_mode[d]  = mode;
    @(posedge clk); #1;
    // Scramble the request lines: the pending access must not see this.
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = ~addr;
    req_wdata[d] = ~wdata;
    req_mode[d]  = mode ^ 3'b010;
    check({name, ":ready_busy"}, {31'b0, req_ready_v[d]}, 32'd0);

    lat = 0;
    while (!resp_valid_v[d] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check({name, ":latency"}, lat, wc + 1);

    e = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      // A competing store offered during RESP must be ignored.
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_addr[d]  = 32'h10;
      req_wdata[d] = 32'hBAD0BAD0;
      req_mode[d]  = LW;
      @(posedge clk); #1;
      check({name, ":hold_valid"}, {31'b0, resp_valid_v[d]}, 32'd1);
      check({name, ":hold_ready"}, {31'b0, req_ready_v[d]}, 32'd0);
      check({name, ":hold_rdata"}, resp_rdata_v[d], e.rdata);
      check({name, ":hold_err"},   {31'b0, resp_err_v[d]}, {31'b0, e.err});
    end
    check({name, ":rdata"}, resp_rdata_v[d], e.rdata);
    check({name, ":err"},   {31'b0, resp_err_v[d]}, {31'b0, e.err});

    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    check({name, ":valid_drop"}, {31'b0, resp_valid_v[d]}, 32'd0);
    check({name, ":ready_back"}, {31'b0, req_ready_v[d]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    resp_ready = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_mode   = '0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d:req_ready", d),  {31'b0, req_ready_v[d]},  32'd1);
      check($sformatf("rst%0d:resp_valid", d), {31'b0, resp_valid_v[d]}, 32'd0);
      check($sformatf("rst%0d:resp_rdata", d), resp_rdata_v[d],          32'd0);
      check($sformatf("rst%0d:resp_err", d),   {31'b0, resp_err_v[d]},   32'd0);
    end
    rst = 1'b0;

    // Basic word store/load and sub-word accesses.
    transact("sw10",   0, 1'b1, 32'h10, 32'hDEADBEEF, LW,  32'h0,        1'b0, 0);
    transact("lw10",   0, 1'b0, 32'h10, 32'h0,        LW,  32'hDEADBEEF, 1'b0, 0);
    transact("sb13",   0, 1'b1, 32'h13, 32'h1234567F, LB,  32'h0,        1'b0, 0);
    transact("lb13",   0, 1'b0, 32'h13, 32'h0,        LB,  32'h0000007F, 1'b0, 0);
    transact("lw10b",  0, 1'b0, 32'h10, 32'h0,        LW,  32'h7FADBEEF, 1'b0, 5);
    transact("lbu12",  0, 1'b0, 32'h12, 32'h0,        LBU, 32'h000000AD, 1'b0, 0);
    transact("lh10",   0, 1'b0, 32'h10, 32'h0,        LH,  32'hFFFFBEEF, 1'b0, 0);
    transact("lhu10",  0, 1'b0, 32'h10, 32'h0,        LHU, 32'h0000BEEF, 1'b0, 0);
    transact("lb11",   0, 1'b0, 32'h11, 32'h0,        LB,  32'hFFFFFFBE, 1'b0, 0);
    transact("lh12",   0, 1'b0, 32'h12, 32'h0,        LH,  32'h00007FAD, 1'b0, 0);

    // Illegal requests: error, zero data, no array side effect.
    transact("lw11",   0, 1'b0, 32'h11, 32'h0,        LW,     32'h0, 1'b1, 0);
    transact("sh11",   0, 1'b1, 32'h11, 32'h00000000, LH,     32'h0, 1'b1, 0);
    transact("lw10c",  0, 1'b0, 32'h10, 32'h0,        LW,     32'h7FADBEEF, 1'b0, 0);
    transact("st100",  0, 1'b1, 32'h10, 32'h00000000, LBU,    32'h0, 1'b1, 0);
    transact("ld111",  0, 1'b0, 32'h10, 32'h0,        3'b111, 32'h0, 1'b1, 0);
    transact("st011",  0, 1'b1, 32'h10, 32'h00000000, 3'b011, 32'h0, 1'b1, 0);
    transact("lw10d",  0, 1'b0, 32'h10, 32'h0,        LW,     32'h7FADBEEF, 1'b0, 0);
    transact("sh12",   0, 1'b1, 32'h12, 32'hAAAA5555, LH,     32'h0, 1'b0, 0);
    transact("lw10e",  0, 1'b0, 32'h10, 32'h0,        LW,     32'h5555BEEF, 1'b0, 0);

    // Reset while a store sits at its access cycle: the store must vanish.
    transact("sw20",   0, 1'b1, 32'h20, 32'hCAFEF00D, LW, 32'h0, 1'b0, 0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h12345678;
    req_mode[0]  = LW;
    @(posedge clk); #1;            // accepted, counter = 2
    req_valid[0] = 1'b0;
    @(posedge clk); #1;            // counter = 1
    @(posedge clk); #1;            // counter = 0
    rst = 1'b1;
    @(posedge clk); #1;            // reset edge replaces the access
    rst = 1'b0;
    check("mid_rst:resp_valid", {31'b0, resp_valid_v[0]}, 32'd0);
    check("mid_rst:req_ready",  {31'b0, req_ready_v[0]},  32'd1);
    check("mid_rst:resp_rdata", resp_rdata_v[0],          32'd0);
    transact("lw20",   0, 1'b0, 32'h20, 32'h0, LW, 32'hCAFEF00D, 1'b0, 0);

    // Address wrap on the default-size array.
    transact("sw1008", 0, 1'b1, 32'h1008, 32'hA5A55A5A, LW, 32'h0,        1'b0, 0);
    transact("lw08",   0, 1'b0, 32'h08,   32'h0,        LW, 32'hA5A55A5A, 1'b0, 0);

    // Zero wait states, 16-word array: wrap at 0x40.
    transact("b_sw48",  1, 1'b1, 32'h48, 32'h0BADF00D, LW,  32'h0,        1'b0, 0);
    transact("b_lw08",  1, 1'b0, 32'h08, 32'h0,        LW,  32'h0BADF00D, 1'b0, 3);
    transact("b_lhu0a", 1, 1'b0, 32'h0A, 32'h0,        LHU, 32'h00000BAD, 1'b0, 0);
    transact("b_lh49",  1, 1'b0, 32'h49, 32'h0,        LH,  32'h0,        1'b1, 0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, number of word-index bits; the array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, number of wait states inserted before each access (0 permitted).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  CPU presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_mode  input  3  RV32I funct3 addressing mode.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  CPU accepts the response.
REQ-013 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 resp_err  output  1  request was illegal and had no effect.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 exactly in IDLE.
REQ-016 A request SHALL be accepted on an edge with req_valid=1 in IDLE.
- Acceptance latches write, addr, wdata and mode.
- The wait counter loads WAIT_CYCLES.
- The next state is WAIT.
REQ-017 In WAIT, on each edge:
- counter != 0: decrement the counter.
- counter == 0: perform the access, register resp_rdata and resp_err, go to RESP.
REQ-018 Latency SHALL be exact: request accepted at edge N gives resp_valid=1 after edge N+WAIT_CYCLES+1.
REQ-019 In RESP, resp_valid SHALL be 1; resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1, which returns the FSM to IDLE.
REQ-020 No new request SHALL be accepted in the RESP→IDLE handshake cycle; maximum throughput is one request per WAIT_CYCLES+3 cycles.
REQ-021 The word index SHALL be req_addr[ADDR_WIDTH+1:2]; higher address bits are ignored, so addresses wrap modulo 2^(ADDR_WIDTH+2).
REQ-022 Byte lanes SHALL be little-endian; the lane is selected by addr[1:0].
REQ-023 Loads SHALL decode as follows:
- 000 LB: sign-extended byte.
- 001 LH: sign-extended half.
- 010 LW: full word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended half.
REQ-024 Stores SHALL decode as follows; unselected bytes of the word are unchanged:
- 000 SB: byte wdata[7:0] into the addressed lane.
- 001 SH: half wdata[15:0] into the addressed half.
- 010 SW: full word.
REQ-025 resp_err=1 SHALL be returned, with no array write and resp_rdata=0, for any of:
- a half access with addr[0]=1;
- a word access with addr[1:0]!=0;
- mode 011, 110 or 111;
- a store with mode 100 or 101.
REQ-026 A successful store SHALL return resp_err=0 and resp_rdata=0.
REQ-027 The array SHALL be written only in the single WAIT cycle with counter==0, never on acceptance.
REQ-028 The wait counter SHALL be max(1, clog2(WAIT_CYCLES+1)) bits wide.
REQ-029 Request inputs SHALL be ignored outside IDLE; req_* changing after acceptance SHALL NOT affect the pending access.

Reset
REQ-030 rst=1 at an edge SHALL set state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 from the following cycle.
REQ-031 Reset SHALL take priority over every other event; a store pending in WAIT, including one at counter==0 in the same cycle, SHALL NOT be written.
REQ-032 Array contents SHALL NOT be affected by rst; contents before the first write are undefined.

Verification
REQ-033 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0; resp_valid rises exactly WAIT_CYCLES+1 edges after each acceptance.
REQ-034 After REQ-033, SB addr 0x13 wdata 0x7F, then:
- LB 0x13 -> 0x0000007F;
- LW 0x10 -> 0x7FADBEEF;
- LBU 0x12 -> 0x000000AD;
- LH 0x10 -> 0xFFFFBEEF;
- LHU 0x10 -> 0x0000BEEF.
REQ-035 Error cases:
- LW 0x11 -> resp_err=1, resp_rdata=0.
- SH 0x11 -> resp_err=1; a following LW 0x10 is unchanged.
- Store mode 100 -> resp_err=1.
- Mode 111 -> resp_err=1.
REQ-036 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0; the release edge -> IDLE.
REQ-037 Reset mid-operation: SW 0x20 0x12345678 accepted, rst pulsed in WAIT -> next cycle resp_valid=0, req_ready=1; a later LW 0x20 returns the prior contents.
REQ-038 Address wrap: SW to addr 4·2^ADDR_WIDTH+8, then LW 0x8 -> same data; repeat with WAIT_CYCLES=0 and check latency is 1 edge.
